// File: rtl/usb_rx_txn_ctrl_if.sv
// -----------------------------------------------------------------------------
// usb_rx_txn_ctrl_if
// Bus bundle between the USB receive decoder / UTMI transmit path and the
// device transaction sequencer.
//   rx_pid        : PID of the current/last received packet (held after EOP)
//   rx_dev_addr   : token address field
//   rx_endp       : token endpoint field
//   rx_crc_valid  : CRC status, valid in the rx_packet_eop cycle
//   rx_packet_eop : one-cycle end-of-packet strobe
//   hs_req/hs_pid : handshake request and PID, held until hs_ack
//   in_req/in_pid : IN data request and DATA PID, held until in_ack
// Modports: master = sequencer, slave = receiver/transmitter side.
// -----------------------------------------------------------------------------
interface usb_rx_txn_ctrl_if;
   logic [3:0] rx_pid;
   logic [6:0] rx_dev_addr;
   logic [3:0] rx_endp;
   logic       rx_crc_valid;
   logic       rx_packet_eop;
   logic       hs_req;
   logic [3:0] hs_pid;
   logic       hs_ack;
   logic       in_req;
   logic [3:0] in_pid;
   logic       in_ack;

   modport master (
      input  rx_pid, rx_dev_addr, rx_endp, rx_crc_valid, rx_packet_eop,
      input  hs_ack, in_ack,
      output hs_req, hs_pid, in_req, in_pid
   );

   modport slave (
      output rx_pid, rx_dev_addr, rx_endp, rx_crc_valid, rx_packet_eop,
      output hs_ack, in_ack,
      input  hs_req, hs_pid, in_req, in_pid
   );
endinterface

// File: rtl/usb_rx_txn_ctrl.sv
// -----------------------------------------------------------------------------
// usb_rx_txn_ctrl
// Device-side USB transaction sequencer. Accepts OUT/IN/SETUP tokens for this
// device, tracks per-endpoint DATA0/DATA1 toggles, decides ACK/NAK/STALL,
// requests handshakes or IN data from the transmitter and commits/discards
// received OUT/SETUP payloads.
// Ports:
//   clk_i, rst_i          : clock, synchronous active-high reset
//   usb_reset_i           : bus reset, same effect as rst_i
//   dev_addr_cfg_i        : assigned device address
//   ep_enable_i/ep_stall_i: per-endpoint enable / halt
//   ep_rx_ready_i         : OUT buffer has room for one max packet
//   ep_tx_ready_i         : IN buffer holds a packet
//   bus                   : rx decode inputs and tx request/ack (master side)
//   cur_ep_o              : endpoint of the active transaction
//   out_commit_o/out_discard_o, setup_rcvd_o, in_done_o, in_retry_o : pulses
// -----------------------------------------------------------------------------
module usb_rx_txn_ctrl #(
   parameter int NUM_EP      = 4,
   parameter int TIMEOUT_CYC = 400
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 usb_reset_i,
   input  logic [6:0]           dev_addr_cfg_i,
   input  logic [NUM_EP-1:0]    ep_enable_i,
   input  logic [NUM_EP-1:0]    ep_stall_i,
   input  logic [NUM_EP-1:0]    ep_rx_ready_i,
   input  logic [NUM_EP-1:0]    ep_tx_ready_i,
   usb_rx_txn_ctrl_if.master    bus,
   output logic [3:0]           cur_ep_o,
   output logic                 out_commit_o,
   output logic                 out_discard_o,
   output logic                 setup_rcvd_o,
   output logic                 in_done_o,
   output logic                 in_retry_o
);

   localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

   localparam logic [3:0] PID_OUT   = 4'b0001;
   localparam logic [3:0] PID_IN    = 4'b1001;
   localparam logic [3:0] PID_SETUP = 4'b1101;
   localparam logic [3:0] PID_DATA0 = 4'b0011;
   localparam logic [3:0] PID_DATA1 = 4'b1011;
   localparam logic [3:0] PID_ACK   = 4'b0010;
   localparam logic [3:0] PID_NAK   = 4'b1010;
   localparam logic [3:0] PID_STALL = 4'b1110;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_DATA,
      S_SEND_HS,
      S_SEND_IN,
      S_WAIT_HS
   } state_e;

   typedef enum logic [1:0] {
      TOK_OUT,
      TOK_IN,
      TOK_SETUP
   } tok_e;

   state_e            state_q;
   tok_e              tok_q;
   logic [NUM_EP-1:0] toggle_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              hs_req_q;
   logic [3:0]        hs_pid_q;
   logic              in_req_q;
   logic [3:0]        in_pid_q;
   logic [3:0]        cur_ep_q;
   logic              out_commit_q;
   logic              out_discard_q;
   logic              setup_rcvd_q;
   logic              in_done_q;
   logic              in_retry_q;

   // Per-endpoint vectors widened to the full 4-bit endpoint space so they can
   // be indexed directly by rx_endp/cur_ep; unimplemented endpoints read as 0.
   logic [15:0]       ep_enable_x;
   logic [15:0]       ep_stall_x;
   logic [15:0]       ep_rx_ready_x;
   logic [15:0]       ep_tx_ready_x;
   logic [15:0]       toggle_x;
   logic [NUM_EP-1:0] cur_mask;

   assign ep_enable_x   = 16'(ep_enable_i);
   assign ep_stall_x    = 16'(ep_stall_i);
   assign ep_rx_ready_x = 16'(ep_rx_ready_i);
   assign ep_tx_ready_x = 16'(ep_tx_ready_i);
   assign toggle_x      = 16'(toggle_q);
   assign cur_mask      = NUM_EP'(16'h0001 << cur_ep_q);

   logic tok_pid_ok;
   logic tok_ok;
   logic data_ok;
   logic data_is_d1;

   assign tok_pid_ok = (bus.rx_pid == PID_OUT) || (bus.rx_pid == PID_IN) ||
                       (bus.rx_pid == PID_SETUP);
   assign tok_ok     = bus.rx_packet_eop && bus.rx_crc_valid && tok_pid_ok &&
                       (bus.rx_dev_addr == dev_addr_cfg_i) &&
                       (32'(bus.rx_endp) < NUM_EP) && ep_enable_x[bus.rx_endp];
   assign data_ok    = bus.rx_crc_valid &&
                       ((bus.rx_pid == PID_DATA0) || (bus.rx_pid == PID_DATA1));
   assign data_is_d1 = (bus.rx_pid == PID_DATA1);

   // NOTE: all state, including the toggle vector, is updated with
   // non-blocking assignments so every branch sees pre-edge values.
   always_ff @(posedge clk_i) begin
      if (rst_i || usb_reset_i) begin
         state_q       <= S_IDLE;
         tok_q         <= TOK_OUT;
         toggle_q      <= '0;
         cnt_q         <= '0;
         hs_req_q      <= 1'b0;
         hs_pid_q      <= '0;
         in_req_q      <= 1'b0;
         in_pid_q      <= '0;
         cur_ep_q      <= '0;
         out_commit_q  <= 1'b0;
         out_discard_q <= 1'b0;
         setup_rcvd_q  <= 1'b0;
         in_done_q     <= 1'b0;
         in_retry_q    <= 1'b0;
      end else begin
         // Status outputs are single-cycle pulses unless a branch sets them.
         out_commit_q  <= 1'b0;
         out_discard_q <= 1'b0;
         setup_rcvd_q  <= 1'b0;
         in_done_q     <= 1'b0;
         in_retry_q    <= 1'b0;

         case (state_q)
            S_IDLE: begin
               if (tok_ok) begin
                  cur_ep_q <= bus.rx_endp;
                  cnt_q    <= '0;
                  if (bus.rx_pid == PID_IN) begin
                     tok_q <= TOK_IN;
                     if (ep_stall_x[bus.rx_endp]) begin
                        hs_pid_q <= PID_STALL;
                        hs_req_q <= 1'b1;
                        state_q  <= S_SEND_HS;
                     end else if (!ep_tx_ready_x[bus.rx_endp]) begin
                        hs_pid_q <= PID_NAK;
                        hs_req_q <= 1'b1;
                        state_q  <= S_SEND_HS;
                     end else begin
                        in_pid_q <= toggle_x[bus.rx_endp] ? PID_DATA1 : PID_DATA0;
                        in_req_q <= 1'b1;
                        state_q  <= S_SEND_IN;
                     end
                  end else begin
                     tok_q   <= (bus.rx_pid == PID_SETUP) ? TOK_SETUP : TOK_OUT;
                     state_q <= S_WAIT_DATA;
                  end
               end
            end

            S_WAIT_DATA: begin
               // An EOP in the expiry cycle is processed as a packet.
               if (bus.rx_packet_eop) begin
                  if (!data_ok) begin
                     out_discard_q <= 1'b1;
                     state_q       <= S_IDLE;
                  end else if (tok_q == TOK_SETUP) begin
                     // SETUP bypasses halt and buffer-ready and always resets
                     // the endpoint toggle so the data stage starts at DATA1.
                     if (!data_is_d1) begin
                        out_commit_q <= 1'b1;
                        setup_rcvd_q <= 1'b1;
                        toggle_q     <= toggle_q | cur_mask;
                        hs_pid_q     <= PID_ACK;
                        hs_req_q     <= 1'b1;
                        state_q      <= S_SEND_HS;
                     end else begin
                        out_discard_q <= 1'b1;
                        state_q       <= S_IDLE;
                     end
                  end else if (ep_stall_x[cur_ep_q]) begin
                     out_discard_q <= 1'b1;
                     hs_pid_q      <= PID_STALL;
                     hs_req_q      <= 1'b1;
                     state_q       <= S_SEND_HS;
                  end else if (!ep_rx_ready_x[cur_ep_q]) begin
                     out_discard_q <= 1'b1;
                     hs_pid_q      <= PID_NAK;
                     hs_req_q      <= 1'b1;
                     state_q       <= S_SEND_HS;
                  end else begin
                     // A toggle mismatch is a host retry of a packet we already
                     // kept: drop it but still ACK so the host moves on.
                     if (data_is_d1 == toggle_x[cur_ep_q]) begin
                        out_commit_q <= 1'b1;
                        toggle_q     <= toggle_q ^ cur_mask;
                     end else begin
                        out_discard_q <= 1'b1;
                     end
                     hs_pid_q <= PID_ACK;
                     hs_req_q <= 1'b1;
                     state_q  <= S_SEND_HS;
                  end
               end else if (cnt_q == CNT_LAST) begin
                  out_discard_q <= 1'b1;
                  state_q       <= S_IDLE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end

            S_SEND_HS: begin
               if (bus.hs_ack) begin
                  hs_req_q <= 1'b0;
                  state_q  <= S_IDLE;
               end
            end

            S_SEND_IN: begin
               if (bus.in_ack) begin
                  in_req_q <= 1'b0;
                  cnt_q    <= '0;
                  state_q  <= S_WAIT_HS;
               end
            end

            S_WAIT_HS: begin
               if (bus.rx_packet_eop) begin
                  if ((bus.rx_pid == PID_ACK) && bus.rx_crc_valid) begin
                     toggle_q  <= toggle_q ^ cur_mask;
                     in_done_q <= 1'b1;
                  end else begin
                     in_retry_q <= 1'b1;
                  end
                  state_q <= S_IDLE;
               end else if (cnt_q == CNT_LAST) begin
                  in_retry_q <= 1'b1;
                  state_q    <= S_IDLE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end

            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.hs_req    = hs_req_q;
   assign bus.hs_pid    = hs_pid_q;
   assign bus.in_req    = in_req_q;
   assign bus.in_pid    = in_pid_q;
   assign cur_ep_o      = cur_ep_q;
   assign out_commit_o  = out_commit_q;
   assign out_discard_o = out_discard_q;
   assign setup_rcvd_o  = setup_rcvd_q;
   assign in_done_o     = in_done_q;
   assign in_retry_o    = in_retry_q;

endmodule

// File: tb/tb_usb_rx_txn_ctrl.sv
// -----------------------------------------------------------------------------
// tb_usb_rx_txn_ctrl
// Directed self-checking bench for usb_rx_txn_ctrl. Inputs are driven 1 time
// unit after the rising edge; registered outputs are sampled at that point
// after the following edge.
// -----------------------------------------------------------------------------
module tb_usb_rx_txn_ctrl;
   localparam int NUM_EP      = 4;
   localparam int TIMEOUT_CYC = 400;

   localparam logic [3:0] P_OUT   = 4'b0001;
   localparam logic [3:0] P_IN    = 4'b1001;
   localparam logic [3:0] P_SETUP = 4'b1101;
   localparam logic [3:0] P_SOF   = 4'b0101;
   localparam logic [3:0] P_DATA0 = 4'b0011;
   localparam logic [3:0] P_DATA1 = 4'b1011;
   localparam logic [3:0] P_ACK   = 4'b0010;
   localparam logic [3:0] P_NAK   = 4'b1010;
   localparam logic [3:0] P_STALL = 4'b1110;

   logic              clk = 1'b0;
   logic              rst;
   logic              usb_reset;
   logic [6:0]        dev_addr_cfg;
   logic [NUM_EP-1:0] ep_enable;
   logic [NUM_EP-1:0] ep_stall;
   logic [NUM_EP-1:0] ep_rx_ready;
   logic [NUM_EP-1:0] ep_tx_ready;
   logic [3:0]        cur_ep;
   logic              out_commit;
   logic              out_discard;
   logic              setup_rcvd;
   logic              in_done;
   logic              in_retry;

   int n_checks = 0;
   int n_fail   = 0;

   usb_rx_txn_ctrl_if bus ();

   usb_rx_txn_ctrl #(
      .NUM_EP      (NUM_EP),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .usb_reset_i    (usb_reset),
      .dev_addr_cfg_i (dev_addr_cfg),
      .ep_enable_i    (ep_enable),
      .ep_stall_i     (ep_stall),
      .ep_rx_ready_i  (ep_rx_ready),
      .ep_tx_ready_i  (ep_tx_ready),
      .bus            (bus),
      .cur_ep_o       (cur_ep),
      .out_commit_o   (out_commit),
      .out_discard_o  (out_discard),
      .setup_rcvd_o   (setup_rcvd),
      .in_done_o      (in_done),
      .in_retry_o     (in_retry)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_pkt(input logic [3:0] pid, input logic [6:0] addr,
                           input logic [3:0] endp, input logic crc);
      bus.rx_pid        = pid;
      bus.rx_dev_addr   = addr;
      bus.rx_endp       = endp;
      bus.rx_crc_valid  = crc;
      bus.rx_packet_eop = 1'b1;
      step();
      bus.rx_packet_eop = 1'b0;
      bus.rx_crc_valid  = 1'b0;
   endtask

   task automatic ack_hs();
      bus.hs_ack = 1'b1;
      step();
      bus.hs_ack = 1'b0;
   endtask

   task automatic ack_in();
      bus.in_ack = 1'b1;
      step();
      bus.in_ack = 1'b0;
   endtask

   // Counts cycles from the state-entry edge until the timeout pulse appears.
   task automatic wait_timeout(input string tag, input bit is_in);
      int k = 0;
      while (k < 2 * TIMEOUT_CYC && !(is_in ? in_retry : out_discard)) begin
         step();
         k++;
      end
      check(tag, k, TIMEOUT_CYC);
   endtask

   initial begin
      rst               = 1'b1;
      usb_reset         = 1'b0;
      dev_addr_cfg      = 7'd5;
      ep_enable         = '1;
      ep_stall          = '0;
      ep_rx_ready       = '1;
      ep_tx_ready       = '1;
      bus.rx_pid        = '0;
      bus.rx_dev_addr   = '0;
      bus.rx_endp       = '0;
      bus.rx_crc_valid  = 1'b0;
      bus.rx_packet_eop = 1'b0;
      bus.hs_ack        = 1'b0;
      bus.in_ack        = 1'b0;
      step();
      step();
      rst = 1'b0;
      step();

      // Reset state
      check("rst.hs_req", bus.hs_req, 0);
      check("rst.hs_pid", bus.hs_pid, 0);
      check("rst.in_req", bus.in_req, 0);
      check("rst.in_pid", bus.in_pid, 0);
      check("rst.cur_ep", cur_ep, 0);
      check("rst.pulses", {out_commit, out_discard, setup_rcvd, in_done, in_retry}, 0);

      // OUT ep1 DATA0 with toggle 0: commit + ACK, toggle[1] -> 1
      send_pkt(P_OUT, 7'd5, 4'd1, 1'b1);
      check("t1.tok_hs_req", bus.hs_req, 0);
      check("t1.cur_ep", cur_ep, 1);
      send_pkt(P_DATA0, 7'd0, 4'd0, 1'b1);
      check("t1.commit", out_commit, 1);
      check("t1.discard", out_discard, 0);
      check("t1.hs_req", bus.hs_req, 1);
      check("t1.hs_pid", bus.hs_pid, P_ACK);
      step();
      check("t1.hs_req_held", bus.hs_req, 1);
      check("t1.hs_pid_held", bus.hs_pid, P_ACK);
      check("t1.commit_pulse", out_commit, 0);
      ack_hs();
      check("t1.hs_req_drop", bus.hs_req, 0);
      // Repeat DATA0: toggle mismatch -> discard, still ACK
      send_pkt(P_OUT, 7'd5, 4'd1, 1'b1);
      send_pkt(P_DATA0, 7'd0, 4'd0, 1'b1);
      check("t1.rep_discard", out_discard, 1);
      check("t1.rep_commit", out_commit, 0);
      check("t1.rep_hs_pid", bus.hs_pid, P_ACK);
      ack_hs();
      // DATA1 now matches toggle 1 -> commit, toggle[1] -> 0
      send_pkt(P_OUT, 7'd5, 4'd1, 1'b1);
      send_pkt(P_DATA1, 7'd0, 4'd0, 1'b1);
      check("t1.d1_commit", out_commit, 1);
      ack_hs();

      // IN ep2 toggle 0 -> DATA0, host ACK -> in_done, toggle[2] -> 1
      send_pkt(P_IN, 7'd5, 4'd2, 1'b1);
      check("t2.in_req", bus.in_req, 1);
      check("t2.in_pid", bus.in_pid, P_DATA0);
      check("t2.cur_ep", cur_ep, 2);
      check("t2.no_hs", bus.hs_req, 0);
      step();
      check("t2.in_req_held", bus.in_req, 1);
      ack_in();
      check("t2.in_req_drop", bus.in_req, 0);
      send_pkt(P_ACK, 7'd0, 4'd0, 1'b1);
      check("t2.in_done", in_done, 1);
      check("t2.in_retry", in_retry, 0);
      step();
      check("t2.in_done_pulse", in_done, 0);
      // Second IN: DATA1, no host reply -> timeout retry
      send_pkt(P_IN, 7'd5, 4'd2, 1'b1);
      check("t2.in_pid_d1", bus.in_pid, P_DATA1);
      ack_in();
      wait_timeout("t2.in_timeout", 1'b1);
      // Toggle unchanged; ack in the same cycle the request first rises
      send_pkt(P_IN, 7'd5, 4'd2, 1'b1);
      check("t2.in_pid_keep", bus.in_pid, P_DATA1);
      ack_in();
      check("t2.one_cycle_req", bus.in_req, 0);
      send_pkt(P_ACK, 7'd0, 4'd0, 1'b1);
      check("t2.in_done2", in_done, 1);

      // STALL / NAK decisions
      ep_stall[0] = 1'b1;
      send_pkt(P_IN, 7'd5, 4'd0, 1'b1);
      check("t3.stall_req", bus.hs_req, 1);
      check("t3.stall_pid", bus.hs_pid, P_STALL);
      check("t3.stall_no_in", bus.in_req, 0);
      ack_hs();
      ep_stall[0]    = 1'b0;
      ep_tx_ready[3] = 1'b0;
      send_pkt(P_IN, 7'd5, 4'd3, 1'b1);
      check("t3.nak_in_pid", bus.hs_pid, P_NAK);
      check("t3.nak_in_no_in", bus.in_req, 0);
      ack_hs();
      ep_tx_ready[3] = 1'b1;
      ep_rx_ready[1] = 1'b0;
      send_pkt(P_OUT, 7'd5, 4'd1, 1'b1);
      send_pkt(P_DATA0, 7'd0, 4'd0, 1'b1);
      check("t3.nak_out_discard", out_discard, 1);
      check("t3.nak_out_req", bus.hs_req, 1);
      check("t3.nak_out_pid", bus.hs_pid, P_NAK);
      ack_hs();
      ep_rx_ready[1] = 1'b1;

      // OUT with no data packet -> discard after timeout, no handshake
      send_pkt(P_OUT, 7'd5, 4'd1, 1'b1);
      wait_timeout("t3.out_timeout", 1'b0);
      check("t3.out_timeout_no_hs", bus.hs_req, 0);

      // SETUP ep0 with toggle 1 and ep0 halted/full
      send_pkt(P_OUT, 7'd5, 4'd0, 1'b1);
      send_pkt(P_DATA0, 7'd0, 4'd0, 1'b1);
      check("t4.pre_commit", out_commit, 1);
      ack_hs();
      ep_stall[0]    = 1'b1;
      ep_rx_ready[0] = 1'b0;
      send_pkt(P_SETUP, 7'd5, 4'd0, 1'b1);
      send_pkt(P_DATA0, 7'd0, 4'd0, 1'b1);
      check("t4.setup_commit", out_commit, 1);
      check("t4.setup_rcvd", setup_rcvd, 1);
      check("t4.setup_pid", bus.hs_pid, P_ACK);
      ack_hs();
      ep_stall[0]    = 1'b0;
      ep_rx_ready[0] = 1'b1;
      send_pkt(P_OUT, 7'd5, 4'd0, 1'b1);
      send_pkt(P_DATA1, 7'd0, 4'd0, 1'b1);
      check("t4.toggle_is_1", out_commit, 1);
      ack_hs();

      // Ignored packets: wrong address, bad CRC, endpoint == NUM_EP, SOF
      send_pkt(P_OUT, 7'd6, 4'd1, 1'b1);
      check("t5.addr_hs", bus.hs_req, 0);
      send_pkt(P_IN, 7'd5, 4'd1, 1'b0);
      check("t5.crc_in", bus.in_req, 0);
      send_pkt(P_IN, 7'd5, 4'(NUM_EP), 1'b1);
      check("t5.ep_range_in", bus.in_req, 0);
      check("t5.ep_range_hs", bus.hs_req, 0);
      send_pkt(P_SOF, 7'd5, 4'd1, 1'b1);
      check("t5.sof", {bus.hs_req, bus.in_req}, 0);
      send_pkt(P_DATA0, 7'd0, 4'd0, 1'b1);
      check("t5.still_idle", {out_commit, out_discard}, 0);
      // Bad-CRC data after OUT -> discard, no handshake
      send_pkt(P_OUT, 7'd5, 4'd1, 1'b1);
      send_pkt(P_DATA0, 7'd0, 4'd0, 1'b0);
      check("t5.badcrc_discard", out_discard, 1);
      check("t5.badcrc_no_hs", bus.hs_req, 0);
      step();
      check("t5.badcrc_no_hs2", bus.hs_req, 0);

      // rst while hs_req held
      ep_stall[0] = 1'b1;
      send_pkt(P_IN, 7'd5, 4'd0, 1'b1);
      check("t6.pre_rst_req", bus.hs_req, 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("t6.rst_hs_req", bus.hs_req, 0);
      check("t6.rst_hs_pid", bus.hs_pid, 0);
      ep_stall[0] = 1'b0;
      // Set toggle[2] and toggle[1], then usb_reset mid-IN
      send_pkt(P_IN, 7'd5, 4'd2, 1'b1);
      check("t6.t2_after_rst", bus.in_pid, P_DATA0);
      ack_in();
      send_pkt(P_ACK, 7'd0, 4'd0, 1'b1);
      send_pkt(P_OUT, 7'd5, 4'd1, 1'b1);
      send_pkt(P_DATA0, 7'd0, 4'd0, 1'b1);
      check("t6.t1_commit", out_commit, 1);
      ack_hs();
      send_pkt(P_IN, 7'd5, 4'd2, 1'b1);
      check("t6.t2_set", bus.in_pid, P_DATA1);
      usb_reset = 1'b1;
      step();
      usb_reset = 1'b0;
      check("t6.ureset_in_req", bus.in_req, 0);
      check("t6.ureset_in_pid", bus.in_pid, 0);
      send_pkt(P_IN, 7'd5, 4'd2, 1'b1);
      check("t6.t2_cleared", bus.in_pid, P_DATA0);
      ack_in();
      send_pkt(P_NAK, 7'd0, 4'd0, 1'b1);
      check("t6.host_nak_retry", in_retry, 1);
      check("t6.host_nak_done", in_done, 0);
      send_pkt(P_OUT, 7'd5, 4'd1, 1'b1);
      send_pkt(P_DATA1, 7'd0, 4'd0, 1'b1);
      check("t6.t1_cleared", out_discard, 1);
      ack_hs();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/usb_rx_txn_ctrl.md
# usb_rx_txn_ctrl

Device-side transaction sequencer that sits downstream of the USB receive state machine and upstream of the UTMI transmit path. It watches decoded packet boundaries (PID, address, endpoint, CRC status) and sequences each token/data/handshake transaction. It tracks per-endpoint DATA0/DATA1 toggles and decides ACK/NAK/STALL. It then requests either a handshake or an IN data packet from the transmitter and commits or discards received OUT/SETUP payloads.

## Interface
- NUM_EP, 4: endpoints supported (1..16); endpoint numbers >= NUM_EP are ignored.
- TIMEOUT_CYC, 400: clk cycles to wait for a host DATA or handshake packet before abandoning the transaction.
- clk  in  1  system clock (60 MHz nominal); the only clock.
- rst  in  1  synchronous, active-high reset.
- usb_reset  in  1  bus reset seen; same effect as rst on state and toggles.
- dev_addr_cfg  in  7  assigned device address.
- ep_enable / ep_stall  in  NUM_EP  per-endpoint enable / halt flags.
- ep_rx_ready  in  NUM_EP  OUT buffer has space for one max packet.
- ep_tx_ready  in  NUM_EP  IN buffer holds a packet to send.
- rx_pid  in  4  PID of the current/last packet (held after EOP).
- rx_dev_addr  in  7  token address field.
- rx_endp  in  4  token endpoint field.
- rx_crc_valid  in  1  CRC status of the last packet; valid in the rx_packet_eop cycle.
- rx_packet_eop  in  1  one-cycle end-of-packet strobe.
- hs_req  out  1  handshake request; held until hs_ack.
- hs_pid  out  4  handshake PID: ACK 0010, NAK 1010, STALL 1110.
- hs_ack  in  1  transmitter accepted the handshake.
- in_req  out  1  IN data request; held until in_ack.
- in_pid  out  4  DATA0 0011 or DATA1 1011.
- in_ack  in  1  IN data packet fully transmitted.
- cur_ep  out  4  endpoint of the active transaction.
- out_commit / out_discard  out  1  one-cycle pulses: keep or drop the buffered OUT/SETUP payload for cur_ep.
- setup_rcvd  out  1  one-cycle pulse on a committed SETUP.
- in_done / in_retry  out  1  one-cycle pulses: IN delivered (host ACK) / must be resent.

## Operation
- States: IDLE, WAIT_DATA, SEND_HS, SEND_IN, WAIT_HS.
- Token acceptance, in IDLE on rx_packet_eop:
  - Requires rx_pid in {OUT 0001, IN 1001, SETUP 1101}, rx_crc_valid=1, rx_dev_addr==dev_addr_cfg, rx_endp<NUM_EP and ep_enable[rx_endp].
  - On acceptance, latch cur_ep and the token type.
  - Any other packet (SOF, PING, foreign address, bad CRC) is ignored and the block stays in IDLE.
- Accepted IN:
  - ep_stall → SEND_HS with STALL.
  - else !ep_tx_ready → SEND_HS with NAK.
  - else → SEND_IN with in_pid = toggle[ep] ? DATA1 : DATA0.
- Accepted OUT/SETUP → WAIT_DATA; clear the timeout counter.
- WAIT_DATA, on rx_packet_eop:
  - Non-DATA0/DATA1 PID or bad CRC → out_discard, no handshake, → IDLE.
  - SETUP with DATA0 → out_commit, setup_rcvd, toggle[ep]←1, ACK. SETUP ignores ep_stall and ep_rx_ready.
  - SETUP with DATA1 → out_discard, → IDLE.
  - OUT with ep_stall → out_discard, STALL.
  - OUT with !ep_rx_ready → out_discard, NAK.
  - OUT whose DATA PID matches toggle → out_commit, toggle flips, ACK.
  - OUT whose DATA PID mismatches toggle → out_discard, ACK, toggle unchanged.
- SEND_HS: hs_req=1, hs_pid stable; on hs_ack → IDLE.
- SEND_IN: in_req=1; on in_ack → WAIT_HS, clear timeout counter.
- WAIT_HS:
  - On rx_packet_eop with ACK PID and good CRC → toggle flips, in_done, → IDLE.
  - Any other packet → in_retry, → IDLE, toggle unchanged.
- Timeout: in WAIT_DATA or WAIT_HS, counter reaching TIMEOUT_CYC-1 → IDLE; WAIT_DATA emits out_discard, WAIT_HS emits in_retry.
- Toggles: NUM_EP-bit register, reset to 0.

## Timing
- Reset (rst or usb_reset, synchronous, highest priority, honoured mid-transaction):
  - State IDLE, all toggles 0, counter 0.
  - hs_req=0, hs_pid=0, in_req=0, in_pid=0, cur_ep=0, all pulses 0.
  - A held hs_req/in_req drops the cycle after reset is sampled.
- Decision latency: outputs (hs_req, in_req, pulses, toggle update) are registered and appear the cycle after the rx_packet_eop cycle.
- hs_req/in_req with hs_pid/in_pid/cur_ep stay stable until the ack is sampled high, then drop the next cycle. An ack while the matching request is low is ignored.
- Ack in the same cycle as the request's first assertion is legal; the request lasts exactly one cycle.
- rx_packet_eop while in SEND_HS or SEND_IN is ignored; the transmitter owns the bus.
- Timeout counter counts clk cycles from state entry. The exit pulse occurs TIMEOUT_CYC cycles after entry.
- EOP in the same cycle the counter expires: the EOP wins.

## Test plan
- OUT token to addr 5 ep1 (dev_addr_cfg=5), then DATA0 good CRC, ep_rx_ready=1, toggle 0 → out_commit, hs_pid=ACK, toggle[1]=1; a repeat DATA0 → out_discard, ACK, toggle stays 1.
- IN ep2, ep_tx_ready=1, toggle 0 → in_req with in_pid=0011; in_ack, then host ACK → in_done, toggle[2]=1. Repeat with no host reply → in_retry exactly TIMEOUT_CYC cycles after in_ack, toggle unchanged.
- IN with ep_stall[0]=1 → STALL; IN with ep_tx_ready=0 → NAK; OUT with ep_rx_ready=0 → NAK plus out_discard.
- SETUP ep0 with toggle 1 and ep_stall[0]=1, then DATA0 → out_commit, setup_rcvd, ACK, toggle[0]=1.
- Tokens with wrong address, bad CRC, rx_endp=NUM_EP or SOF → no outputs, stays IDLE. Data packet with bad CRC after OUT → out_discard, no hs_req.
- rst asserted while hs_req is held, and usb_reset after toggles set → hs_req low next cycle, all toggles 0, state IDLE.
